// File: rtl/case_3_mul_pipe_hs.sv
// case_3_mul_pipe_hs: pipelined integer multiplier with valid/ready handshake and clock enable.
// Define CASE_MUL_SAT_EN to clamp narrow results and report ovf; otherwise narrow results wrap.
module case_3_mul_pipe_hs #(
    parameter int          ID         = 1,
    parameter int unsigned NUM_STAGE  = 3,
    parameter int unsigned din0_WIDTH = 6,
    parameter int unsigned din1_WIDTH = 4,
    parameter int unsigned dout_WIDTH = 8,
    parameter int unsigned SIGNED0    = 1,
    parameter int unsigned SIGNED1    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  in_vld,
    output logic                  in_rdy,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic                  ovf
);
    localparam int unsigned P     = din0_WIDTH + din1_WIDTH;
    localparam int unsigned DW    = dout_WIDTH;
    localparam bit          PSIGN = (SIGNED0 != 0) || (SIGNED1 != 0);

    logic unused_id_c;
    assign unused_id_c = ID[0];

    logic                advance_c;
    logic [P-1:0]        a_ext_c, b_ext_c, prod_c, fin_prod_c;
    logic signed [P-1:0] fin_sprod_c;
    logic                fin_vld_c;
    logic [DW-1:0]       res_c, fit_c;
    logic                out_vld_q, out_vld_d;
    logic [DW-1:0]       dout_q, dout_d;

    assign advance_c = ce & (~out_vld_q | out_rdy);
    assign in_rdy    = advance_c;

    // Extend each operand to the full product width; the P-bit product is then exact.
    always_comb begin
        a_ext_c = {{din1_WIDTH{(SIGNED0 != 0) & din0[din0_WIDTH-1]}}, din0};
        b_ext_c = {{din0_WIDTH{(SIGNED1 != 0) & din1[din1_WIDTH-1]}}, din1};
        prod_c  = a_ext_c * b_ext_c;
    end

    generate
        if (NUM_STAGE == 1) begin : g_direct
            assign fin_prod_c = prod_c;
            assign fin_vld_c  = in_vld;
        end else begin : g_pipe
            localparam int unsigned NP = NUM_STAGE - 1;
            logic [P-1:0]  prod_q [NP];
            logic [P-1:0]  prod_d [NP];
            logic [NP-1:0] vld_q, vld_d;

            // One shift per advance; bubbles keep their slot.
            always_comb begin
                prod_d = prod_q;
                vld_d  = vld_q;
                if (advance_c) begin
                    prod_d[0] = prod_c;
                    vld_d[0]  = in_vld;
                    for (int unsigned i = 1; i < NP; i++) begin
                        prod_d[i] = prod_q[i-1];
                        vld_d[i]  = vld_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_q <= '0;
                    for (int unsigned i = 0; i < NP; i++) prod_q[i] <= '0;
                end else begin
                    vld_q  <= vld_d;
                    prod_q <= prod_d;
                end
            end

            assign fin_prod_c = prod_q[NP-1];
            assign fin_vld_c  = vld_q[NP-1];
        end
    endgenerate

    // Resize: sign/zero-extend when wider, keep the low bits when narrower.
    assign fin_sprod_c = fin_prod_c;
    assign res_c       = PSIGN ? DW'(fin_sprod_c) : DW'(fin_prod_c);

`ifdef CASE_MUL_SAT_EN
    logic [DW-1:0] sat_c;
    logic          ovf_c, ovf_q, ovf_d;

    generate
        if (DW < P) begin : g_clamp
            always_comb begin
                sat_c = res_c;
                ovf_c = 1'b0;
                if (PSIGN) begin
                    // Fits only if every bit from the result sign position up is identical.
                    if (!(&fin_prod_c[P-1:DW-1]) && (|fin_prod_c[P-1:DW-1])) begin
                        ovf_c = 1'b1;
                        sat_c = fin_prod_c[P-1] ? {1'b1, {(DW-1){1'b0}}}
                                                : {1'b0, {(DW-1){1'b1}}};
                    end
                end else if (|fin_prod_c[P-1:DW]) begin
                    ovf_c = 1'b1;
                    sat_c = '1;
                end
            end
        end else begin : g_noclamp
            assign sat_c = res_c;
            assign ovf_c = 1'b0;
        end
    endgenerate

    assign fit_c = sat_c;

    always_comb begin
        ovf_d = ovf_q;
        if (advance_c) ovf_d = fin_vld_c & ovf_c;
    end

    always_ff @(posedge clk) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    assign fit_c = res_c;
    assign ovf   = 1'b0;
`endif

    // Output register: loads on advance, holds under stall or ce=0.
    always_comb begin
        out_vld_d = out_vld_q;
        dout_d    = dout_q;
        if (advance_c) begin
            out_vld_d = fin_vld_c;
            if (fin_vld_c) dout_d = fit_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            dout_q    <= dout_d;
        end
    end

    assign out_vld = out_vld_q;
    assign dout    = dout_q;

endmodule

// File: tb/tb_case_3_mul_pipe_hs.sv
// Bench for case_3_mul_pipe_hs at default parameters (wrap or CASE_MUL_SAT_EN build).
module tb_case_3_mul_pipe_hs;
    localparam int NS = 3;
    localparam int NV = 11;

    logic       clk = 1'b0;
    logic       reset, ce, in_vld, in_rdy, out_vld, out_rdy, ovf;
    logic [5:0] din0;
    logic [3:0] din1;
    logic [7:0] dout;

    always #5 clk = ~clk;

    case_3_mul_pipe_hs #(
        .ID(1), .NUM_STAGE(NS), .din0_WIDTH(6), .din1_WIDTH(4),
        .dout_WIDTH(8), .SIGNED0(1), .SIGNED1(1)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1),
        .in_vld(in_vld), .in_rdy(in_rdy), .dout(dout), .out_vld(out_vld),
        .out_rdy(out_rdy), .ovf(ovf)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       o;
    } res_t;

    typedef struct packed {
        logic [5:0] a;
        logic [3:0] b;
        logic [7:0] d;
        logic       o;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    res_t m_d [NS];
    logic m_v [NS];
    res_t got_q [$];
    res_t exp_q [$];
    bit   acc;
    vec_t vt [NV];

    function automatic res_t ref_mul(input logic [5:0] a, input logic [3:0] b);
        int   p;
        res_t r;
        p   = int'($signed(a)) * int'($signed(b));
        r.d = 8'(p);
        r.o = 1'b0;
`ifdef CASE_MUL_SAT_EN
        if (p > 127) begin
            r.d = 8'h7F; r.o = 1'b1;
        end else if (p < -128) begin
            r.d = 8'h80; r.o = 1'b1;
        end
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: check in_rdy, log output transfers, update the model, check outputs.
    task automatic tick();
        logic adv;
        bit   was_rst;
        #1;
        adv     = ce & (~m_v[NS-1] | out_rdy);
        was_rst = reset;
        if (!reset) check("in_rdy", in_rdy, adv);
        acc = !reset && in_vld && in_rdy;
        if (!reset && out_vld && out_rdy && ce) got_q.push_back({dout, ovf});
        @(posedge clk);
        if (was_rst) begin
            for (int i = 0; i < NS; i++) begin
                m_v[i] = 1'b0;
                m_d[i] = '0;
            end
        end else if (adv) begin
            for (int i = NS - 1; i > 0; i--) begin
                m_v[i] = m_v[i-1];
                m_d[i] = m_d[i-1];
            end
            m_v[0] = in_vld;
            m_d[0] = ref_mul(din0, din1);
        end
        #1;
        check("out_vld", out_vld, m_v[NS-1]);
        if (m_v[NS-1] || was_rst) begin
            check("dout", dout, m_d[NS-1].d);
            check("ovf", ovf, m_d[NS-1].o);
        end
    endtask

    task automatic drain();
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        repeat (NS + 3) tick();
    endtask

    task automatic compare_q(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(name, {got_q[i].d, got_q[i].o}, {exp_q[i].d, exp_q[i].o});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        int cyc;

`ifdef CASE_MUL_SAT_EN
        vt[1]  = {6'h20, 4'h8, 8'h7F, 1'b1};
        vt[2]  = {6'h1F, 4'h7, 8'h7F, 1'b1};
        vt[3]  = {6'h20, 4'h7, 8'h80, 1'b1};
        vt[7]  = {6'h1F, 4'h8, 8'h80, 1'b1};
        vt[8]  = {6'h30, 4'h8, 8'h7F, 1'b1};
`else
        vt[1]  = {6'h20, 4'h8, 8'h00, 1'b0};
        vt[2]  = {6'h1F, 4'h7, 8'hD9, 1'b0};
        vt[3]  = {6'h20, 4'h7, 8'h20, 1'b0};
        vt[7]  = {6'h1F, 4'h8, 8'h08, 1'b0};
        vt[8]  = {6'h30, 4'h8, 8'h80, 1'b0};
`endif
        vt[0]  = {6'h05, 4'hD, 8'hF1, 1'b0};
        vt[4]  = {6'h02, 4'h3, 8'h06, 1'b0};
        vt[5]  = {6'h00, 4'h8, 8'h00, 1'b0};
        vt[6]  = {6'h3F, 4'hF, 8'h01, 1'b0};
        vt[9]  = {6'h10, 4'h8, 8'h80, 1'b0};
        vt[10] = {6'h12, 4'h7, 8'h7E, 1'b0};

        for (int i = 0; i < NS; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = '0;
        end
        reset = 1'b1; ce = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
        din0 = '0; din1 = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rdy_after_reset", in_rdy, 1);

        // Single op 5 * -3 = -15, visible after three edges for one cycle.
        din0 = 6'h05; din1 = 4'hD; in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        lat = 1;
        while (!out_vld && lat < 10) begin
            tick();
            lat++;
        end
        check("latency", lat, NS);
        check("single_dout", dout, 8'hF1);
        tick();
        check("single_pulse", out_vld, 0);
        drain();

        // Table vectors back-to-back, results collected in order.
        got_q.delete();
        for (int i = 0; i < NV; i++) begin
            din0 = vt[i].a; din1 = vt[i].b; in_vld = 1'b1;
            tick();
            check("table_acc", acc, 1);
        end
        drain();
        check("table_count", got_q.size(), NV);
        for (int i = 0; i < NV && i < got_q.size(); i++) begin
            check("table_dout", got_q[i].d, vt[i].d);
            check("table_ovf", got_q[i].o, vt[i].o);
        end

        // Ten ops against out_rdy pattern 1,0,0.
        got_q.delete(); exp_q.delete();
        k = 0; cyc = 0;
        while (k < 10 && cyc < 200) begin
            din0 = 6'(k * 7 - 20); din1 = 4'(k - 5); in_vld = 1'b1;
            out_rdy = (cyc % 3 == 0);
            tick();
            if (acc) begin
                exp_q.push_back(ref_mul(din0, din1));
                k++;
            end
            cyc++;
        end
        check("stream_sent", k, 10);
        drain();
        compare_q("stream");

        // ce low for four cycles mid-stream.
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            din0 = 6'(i * 5 + 3); din1 = 4'(7 - i); in_vld = 1'b1;
            ce = !(i >= 3 && i < 7);
            tick();
            if (!ce) check("ce_noacc", acc, 0);
            if (acc) exp_q.push_back(ref_mul(din0, din1));
        end
        ce = 1'b1;
        drain();
        compare_q("ce");

        // Reset with three ops in flight: they vanish, a new op completes.
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            din0 = 6'(i + 9); din1 = 4'h5; in_vld = 1'b1;
            tick();
        end
        in_vld = 1'b0;
        reset  = 1'b1;
        tick();
        check("rst_vld", out_vld, 0);
        check("rst_dout", dout, 0);
        reset = 1'b0;
        got_q.delete();
        din0 = 6'h02; din1 = 4'h3; in_vld = 1'b1;
        tick();
        check("post_rst_acc", acc, 1);
        drain();
        check("post_rst_count", got_q.size(), 1);
        if (got_q.size() > 0) check("post_rst_dout", got_q[0].d, 8'h06);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
